// File: rtl/result_sender_pkg.sv
// Shared matrix definitions: FSM states, byte phases, size limits
// and the header byte layout used by the result sender.
package result_sender_pkg;

    localparam int MAX_SIZE_DEF = 8;
    localparam logic [3:0] HDR_UPPER = 4'h0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        LATCH,
        SEND,
        WAIT_ACK,
        WAIT_FREE,
        FINISH
    } state_e;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_HI,
        PH_LO
    } phase_e;

    function automatic logic [7:0] hdr_byte(input logic [3:0] n);
        return {HDR_UPPER, n};
    endfunction

endpackage

// File: rtl/result_sender.sv
// Streams an NxN result matrix out over a byte UART: header byte,
// then each element high byte first, handshaking on tx_busy.
module result_sender
    import result_sender_pkg::*;
#(
    parameter int MAX_SIZE = MAX_SIZE_DEF,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        matrix_size,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    phase_e            ph_q, ph_d;
    logic [3:0]        n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        lo_q, lo_d;
    logic              err_q, err_d;
    logic [7:0]        sq;
    logic              bad_size;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ph_q    <= PH_HDR;
            n_q     <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            byte_q  <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        n_d      = n_q;
        idx_d    = idx_q;
        last_d   = last_q;
        byte_d   = byte_q;
        lo_d     = lo_q;
        err_d    = err_q;
        sq       = {4'h0, matrix_size} * {4'h0, matrix_size};
        bad_size = (matrix_size == 4'd0) || (int'(matrix_size) > MAX_SIZE);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = matrix_size;
                    idx_d = '0;
                    if (bad_size) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        err_d   = 1'b0;
                        last_d  = ADDR_W'(sq - 8'd1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                byte_d  = hdr_byte(n_q);
                ph_d    = PH_HDR;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) state_d = WAIT_FREE;
            end
            WAIT_FREE: begin
                if (!tx_busy) begin
                    unique case (ph_q)
                        PH_HDR: state_d = FETCH;
                        PH_HI: begin
                            byte_d  = lo_q;
                            ph_d    = PH_LO;
                            state_d = SEND;
                        end
                        default: begin
                            if (idx_q == last_q) begin
                                state_d = FINISH;
                            end else begin
                                idx_d   = idx_q + 1'b1;
                                state_d = FETCH;
                            end
                        end
                    endcase
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                byte_d  = rd_data[15:8];
                lo_d    = rd_data[7:0];
                ph_d    = PH_HI;
                state_d = SEND;
            end
            FINISH: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_en    = (state_q == FETCH);
    assign rd_addr  = idx_q;
    assign tx_data  = byte_q;
    assign tx_start = (state_q == SEND) && !tx_busy;
    assign busy     = (state_q != IDLE) && (state_q != FINISH);
    assign done     = (state_q == FINISH);
    assign err      = (state_q == FINISH) && err_q;

endmodule

// File: tb/tb_result_sender.sv
// Directed + randomized bench for result_sender with a UART busy
// model, a registered result memory and a frame-level reference.
module tb_result_sender;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  matrix_size;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        busy;
    logic        done;
    logic        err;

    result_sender dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .matrix_size(matrix_size),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [64];
    byte unsigned rxq [$];
    int cyc = 0;
    int ntx, nrd, ndone, nerr, first_tx, done_cyc, scyc;
    int viol = 0;
    int bsy_cnt = 0;
    int blen_fix = 3;
    logic hold = 1'b0;
    logic pend = 1'b0;
    logic [7:0] pend_byte = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (tx_start)
            bsy_cnt <= (blen_fix != 0) ? blen_fix : int'($urandom_range(1, 4));
        else if (bsy_cnt != 0)
            bsy_cnt <= bsy_cnt - 1;
    end
    assign tx_busy = hold | (bsy_cnt != 0);

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (!rst_n) pend = 1'b0;
        if (pend) begin
            if (tx_busy) pend = 1'b0;
            else if (tx_data !== pend_byte) viol++;
        end
        if (tx_start) begin
            rxq.push_back(tx_data);
            ntx++;
            if (first_tx < 0) first_tx = cyc;
            if (tx_busy) viol++;
            pend = 1'b1;
            pend_byte = tx_data;
        end
        if (rd_en) nrd++;
        if (done) begin
            ndone++;
            done_cyc = cyc;
            if (err) nerr++;
        end
        if (err && !done) viol++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        rxq.delete();
        ntx = 0; nrd = 0; ndone = 0; nerr = 0;
        first_tx = -1; done_cyc = -1;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < 64; i++)
            mem[i] = rnd ? 16'($urandom) : 16'(((2*i+1) << 8) | (2*i+2));
    endtask

    task automatic pulse_start(input logic [3:0] n);
        @(negedge clk);
        start = 1'b1;
        matrix_size = n;
        scyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (ndone == 0 && k < bound) begin
            @(negedge clk); #1;
            k++;
        end
        chk({tag, "_done_seen"}, longint'(ndone != 0), 1);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_once"}, ndone, 1);
    endtask

    task automatic check_frame(input string tag, input int n);
        byte unsigned exp [$];
        exp.push_back(8'(n));
        for (int i = 0; i < n*n; i++) begin
            exp.push_back(mem[i][15:8]);
            exp.push_back(mem[i][7:0]);
        end
        chk({tag, "_nbytes"}, rxq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rxq.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), rxq[i], exp[i]);
        chk({tag, "_nrd"}, nrd, n*n);
        chk({tag, "_err"}, nerr, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
    endtask

    task automatic illegal(input string tag, input logic [3:0] n);
        clr();
        pulse_start(n);
        wait_done(tag, 20);
        chk({tag, "_err"}, nerr, 1);
        chk({tag, "_lat"}, done_cyc - scyc, 1);
        chk({tag, "_ntx"}, ntx, 0);
        chk({tag, "_nrd"}, nrd, 0);
    endtask

    initial begin
        int n, k, snap, rel;
        start = 1'b0;
        matrix_size = 4'd0;
        rst_n = 1'b0;
        clr();
        fill_mem(1'b0);
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("reset");
        rst_n = 1'b1;

        // Reference frame with a 3-cycle busy UART
        for (int i = 0; i < 4; i++)
            mem[i] = 16'(((2*i+1) << 8) | (2*i+2));
        clr();
        pulse_start(4'd2);
        wait_done("n2", 500);
        check_frame("n2", 2);
        chk("n2_hdr_lat", first_tx - scyc, 2);

        illegal("n0", 4'd0);
        illegal("n9", 4'd9);
        illegal("n15", 4'd15);

        // Random sizes, contents and busy lengths
        blen_fix = 0;
        for (int t = 0; t < 6; t++) begin
            n = (t == 0) ? 8 : int'($urandom_range(1, 8));
            fill_mem(1'b1);
            clr();
            pulse_start(4'(n));
            wait_done($sformatf("rnd%0d", t), 5000);
            check_frame($sformatf("rnd%0d", t), n);
            chk($sformatf("rnd%0d_lat", t), first_tx - scyc, 2);
        end

        // UART stuck busy before the header
        blen_fix = 3;
        fill_mem(1'b1);
        clr();
        hold = 1'b1;
        pulse_start(4'd1);
        repeat (50) @(negedge clk);
        #1;
        chk("hold_no_tx", ntx, 0);
        @(posedge clk); #1;
        hold = 1'b0;
        rel = cyc;
        wait_done("hold", 200);
        chk("hold_after_release", longint'(first_tx >= rel), 1);
        check_frame("hold", 1);

        // Reset in the middle of an N=3 frame
        fill_mem(1'b1);
        clr();
        pulse_start(4'd3);
        k = 0;
        while (rxq.size() < 4 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        chk("mid_reach4", longint'(rxq.size() >= 4), 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("mid_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap = ntx;
        repeat (20) @(negedge clk);
        #1;
        chk("post_rst_quiet", ntx, snap);
        chk("post_rst_nodone", ndone, 0);
        fill_mem(1'b1);
        clr();
        pulse_start(4'd1);
        wait_done("post_rst", 200);
        check_frame("post_rst", 1);

        // Extra start while a frame is in flight
        fill_mem(1'b1);
        clr();
        pulse_start(4'd2);
        k = 0;
        while (rxq.size() < 3 && k < 500) begin
            @(negedge clk); #1;
            k++;
        end
        chk("dup_reach3", longint'(rxq.size() >= 3), 1);
        pulse_start(4'd3);
        wait_done("dup", 500);
        check_frame("dup", 2);

        chk("protocol_viol", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_sender.md
RESULT_SENDER -- requirements
Module: result_sender

Interface
REQ-001 Parameter: MAX_SIZE, default 8, largest legal matrix dimension.
REQ-002 Parameter: DATA_W, default 16, result element width in bits.
REQ-003 Parameter: ADDR_W, default 6, result memory address width; must satisfy 2**ADDR_W >= MAX_SIZE*MAX_SIZE.
REQ-004 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port: start  input  1  one-cycle request to transmit the result matrix.
REQ-007 Port: matrix_size  input  4  matrix dimension N, sampled on accepted start.
REQ-008 Port: rd_en  output  1  result memory read strobe.
REQ-009 Port: rd_addr  output  ADDR_W  result memory address, row-major index.
REQ-010 Port: rd_data  input  DATA_W  result memory data, valid exactly 1 cycle after rd_en.
REQ-011 Port: tx_data  output  8  byte presented to UART transmitter.
REQ-012 Port: tx_start  output  1  one-cycle UART launch pulse.
REQ-013 Port: tx_busy  input  1  UART transmitter busy.
REQ-014 Port: busy  output  1  high from accepted start until done.
REQ-015 Port: done  output  1  one-cycle completion pulse.
REQ-016 Port: err  output  1  one-cycle pulse, coincident with done, for illegal size.

Function
REQ-017 start SHALL be accepted only in IDLE; start while busy is ignored, no state change.
REQ-018 Transmit frame SHALL be: one header byte {4'h0, N}, then N*N elements row-major, each high byte first, then low byte; total 1 + 2*N*N bytes.
REQ-019 States SHALL be IDLE, LOAD, FETCH, LATCH, SEND, WAIT_ACK, WAIT_FREE, FINISH.
REQ-020 IDLE->LOAD on accepted start; LOAD places header in byte register, goes to SEND.
REQ-021 SEND SHALL assert tx_start for exactly one cycle, only when tx_busy is low, with tx_data stable from that cycle until tx_busy is next seen high; if tx_busy is high it stays in SEND.
REQ-022 WAIT_ACK holds until tx_busy high; WAIT_FREE holds until tx_busy low; then: header sent -> FETCH; high byte sent -> SEND with low byte; low byte sent -> FETCH if elements remain, else FINISH.
REQ-023 FETCH SHALL pulse rd_en with rd_addr = element index; LATCH captures rd_data into the element register and selects the high byte, then goes to SEND.
REQ-024 Element index SHALL count 0..N*N-1, never wrap past N*N-1.
REQ-025 FINISH SHALL pulse done one cycle and return to IDLE; busy deasserts the same cycle done is high.
REQ-026 N==0 or N>MAX_SIZE: no bytes sent, no rd_en; done and err pulse in the cycle after start; back to IDLE.
REQ-027 Latency: tx_start for header SHALL occur 2 cycles after accepted start when tx_busy is low.
REQ-028 N*N SHALL be computed at 8-bit width, no truncation for N<=15.
REQ-029 tx_busy held high indefinitely SHALL stall the block without timeout or byte loss.

Reset
REQ-030 rst_n low SHALL immediately force IDLE; rd_en, tx_start, busy, done, err to 0; rd_addr, tx_data, counters, registers to 0.
REQ-031 Reset mid-frame SHALL abandon the frame; after release no byte is sent until a new start.

Structure
REQ-032 State encoding, MAX_SIZE default and header format constant SHALL live in the shared matrix package used by the control path.
REQ-033 Single module; no sub-module required; byte-handshake logic stays inline.

Verification
REQ-034 N=2, memory {0x0102,0x0304,0x0506,0x0708}, tx_busy 3-cycle model -> bytes 02,01,02,03,04,05,06,07,08, then one done, err=0.
REQ-035 N=0 start -> done and err pulse next cycle, zero tx_start, zero rd_en.
REQ-036 N=9 (MAX_SIZE=8) -> same as REQ-035.
REQ-037 N=1, tx_busy held high 50 cycles before header -> tx_start only after tx_busy falls; 3 bytes total.
REQ-038 rst_n low after 4th byte of N=3 frame -> all outputs 0 asynchronously; new start with N=1 sends clean 3-byte frame.
REQ-039 Second start mid-frame -> ignored; byte count and contents unchanged.
